// File: rtl/cw305_pulpino_pkg.sv
// rtl/cw305_pulpino_pkg.sv - shared types and register map for the CW305/PULPino mailbox
package cw305_pulpino_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_BUSY    = 2'd2
    } state_e;

    // APB byte offsets; each 128-bit block spans four consecutive words
    localparam logic [7:0] OFF_STATUS    = 8'h00;
    localparam logic [7:0] OFF_CTRL      = 8'h04;
    localparam logic [7:0] OFF_TEXTIN    = 8'h10;
    localparam logic [7:0] OFF_KEY       = 8'h20;
    localparam logic [7:0] OFF_TEXTOUT   = 8'h30;
    localparam logic [7:0] OFF_CIPHEROUT = 8'h40;

    localparam int STAT_PENDING = 0;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_OVERRUN = 2;
    localparam int STAT_TIMEOUT = 3;

    localparam int CTRL_ACK     = 0;
    localparam int CTRL_DONE    = 1;
    localparam int CTRL_CLR_OVR = 2;
    localparam int CTRL_CLR_TO  = 3;

    // Word n of a 128-bit register occupies bits [32n+31:32n]
    function automatic logic [31:0] word_of(input logic [127:0] r, input logic [1:0] n);
        return r[32*n +: 32];
    endfunction

endpackage

// File: rtl/cw305_mailbox_apb_regs.sv
// rtl/cw305_mailbox_apb_regs.sv - APB decode, operand snapshots and result registers
module cw305_mailbox_apb_regs
    import cw305_pulpino_pkg::*;
#(
    parameter int unsigned pAPB_ADDR_WIDTH = 12
) (
    input  logic                       crypto_clk,
    input  logic                       reset_n,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [pAPB_ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]                pwdata,
    output logic [31:0]                prdata,
    output logic                       pready,
    output logic                       pslverr,
    input  logic                       snap_en,
    input  logic [127:0]               textin_i,
    input  logic [127:0]               key_i,
    input  logic [3:0]                 status,
    output logic [127:0]               textout,
    output logic [127:0]               cipherout,
    output logic [3:0]                 ctrl_wr
);

    logic [127:0] textin_q;
    logic [127:0] key_q;
    logic [127:0] textout_q;
    logic [127:0] cipherout_q;
    logic [7:0]   off;
    logic [3:0]   blk;
    logic [1:0]   wsel;
    logic         mapped;
    logic         ro;
    logic         access;
    logic         wr_ok;

    // Decode the byte offset into a block, a word select and its access rights
    always_comb begin
        off    = paddr[7:0];
        blk    = off[7:4];
        wsel   = off[3:2];
        mapped = 1'b0;
        ro     = 1'b0;
        if (((paddr >> 8) == '0) && (off[1:0] == 2'b00)) begin
            case (blk)
                OFF_STATUS[7:4]: begin
                    mapped = (off == OFF_STATUS) || (off == OFF_CTRL);
                    ro     = (off == OFF_STATUS);
                end
                OFF_TEXTIN[7:4], OFF_KEY[7:4]: begin
                    mapped = 1'b1;
                    ro     = 1'b1;
                end
                OFF_TEXTOUT[7:4], OFF_CIPHEROUT[7:4]: mapped = 1'b1;
                default: mapped = 1'b0;
            endcase
        end
    end

    assign access  = psel & penable;
    assign wr_ok   = access & pwrite & mapped & ~ro;
    assign pready  = 1'b1;
    assign pslverr = access & (~mapped | (pwrite & ro));
    assign ctrl_wr = (wr_ok && (off == OFF_CTRL)) ? pwdata[3:0] : 4'd0;

    // Read mux: only while selected, CTRL and unmapped offsets read as zero
    always_comb begin
        prdata = 32'd0;
        if (psel && mapped) begin
            case (blk)
                OFF_STATUS[7:4]:    prdata = (off == OFF_STATUS) ? {28'd0, status} : 32'd0;
                OFF_TEXTIN[7:4]:    prdata = word_of(textin_q, wsel);
                OFF_KEY[7:4]:       prdata = word_of(key_q, wsel);
                OFF_TEXTOUT[7:4]:   prdata = word_of(textout_q, wsel);
                OFF_CIPHEROUT[7:4]: prdata = word_of(cipherout_q, wsel);
                default:            prdata = 32'd0;
            endcase
        end
    end

    // Capture job operands when the FSM accepts a start request
    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n) begin
            textin_q <= '0;
            key_q    <= '0;
        end else if (snap_en) begin
            textin_q <= textin_i;
            key_q    <= key_i;
        end
    end

    // Software-written result words
    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n) begin
            textout_q   <= '0;
            cipherout_q <= '0;
        end else if (wr_ok) begin
            if (blk == OFF_TEXTOUT[7:4])   textout_q[32*wsel +: 32]   <= pwdata;
            if (blk == OFF_CIPHEROUT[7:4]) cipherout_q[32*wsel +: 32] <= pwdata;
        end
    end

    assign textout   = textout_q;
    assign cipherout = cipherout_q;

endmodule

// File: rtl/cw305_pulpino_mailbox.sv
// rtl/cw305_pulpino_mailbox.sv - job handshake FSM and watchdog between CW305 registers and PULPino
module cw305_pulpino_mailbox
    import cw305_pulpino_pkg::*;
#(
    parameter int unsigned pAPB_ADDR_WIDTH = 12,
    parameter logic [23:0] pTIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic                       crypto_clk,
    input  logic                       reset_n,
    input  logic                       start_i,
    input  logic [127:0]               textin_i,
    input  logic [127:0]               key_i,
    output logic [127:0]               textout_o,
    output logic [127:0]               cipherout_o,
    output logic                       ready_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       irq_o,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [pAPB_ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]                pwdata,
    output logic [31:0]                prdata,
    output logic                       pready,
    output logic                       pslverr
);

    state_e      state_q;
    state_e      state_d;
    logic [23:0] wd_q;
    logic        ovr_q;
    logic        to_q;
    logic        done_q;
    logic        done_d;
    logic        snap_en;
    logic        wd_expire;
    logic [3:0]  ctrl_wr;
    logic [3:0]  status;

    assign wd_expire = (pTIMEOUT_CYCLES != 24'd0) && (state_q == ST_BUSY) &&
                       (wd_q == pTIMEOUT_CYCLES - 24'd1);

    assign status[STAT_PENDING] = (state_q == ST_PENDING);
    assign status[STAT_BUSY]    = (state_q == ST_BUSY);
    assign status[STAT_OVERRUN] = ovr_q;
    assign status[STAT_TIMEOUT] = to_q;

    cw305_mailbox_apb_regs #(
        .pAPB_ADDR_WIDTH (pAPB_ADDR_WIDTH)
    ) u_regs (
        .crypto_clk (crypto_clk),
        .reset_n    (reset_n),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .snap_en    (snap_en),
        .textin_i   (textin_i),
        .key_i      (key_i),
        .status     (status),
        .textout    (textout_o),
        .cipherout  (cipherout_o),
        .ctrl_wr    (ctrl_wr)
    );

    // Next state: start, software ACK/DONE and watchdog expiry
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        snap_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    snap_en = 1'b1;
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                snap_en = start_i;
                if (ctrl_wr[CTRL_ACK] && ctrl_wr[CTRL_DONE]) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (ctrl_wr[CTRL_ACK]) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (ctrl_wr[CTRL_DONE] || wd_expire) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, done pulse and watchdog; the counter only runs while staying in BUSY
    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            wd_q    <= 24'd0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            wd_q    <= ((state_q == ST_BUSY) && (state_d == ST_BUSY)) ? wd_q + 24'd1 : 24'd0;
        end
    end

    // Sticky flags; a same-cycle set beats a software clear, DONE beats expiry
    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            if (start_i && (state_q == ST_BUSY)) ovr_q <= 1'b1;
            else if (ctrl_wr[CTRL_CLR_OVR])      ovr_q <= 1'b0;
            if (wd_expire && !ctrl_wr[CTRL_DONE]) to_q <= 1'b1;
            else if (ctrl_wr[CTRL_CLR_TO])        to_q <= 1'b0;
        end
    end

    assign ready_o = (state_q == ST_IDLE);
    assign busy_o  = (state_q != ST_IDLE);
    assign irq_o   = (state_q == ST_PENDING);
    assign done_o  = done_q;

endmodule
